// File: rtl/parking_access_arbiter.sv
// Purpose: 4-slot parking access sequencer. Synchronizes the gate sensors,
//          arbitrates entry/exit round-robin, owns occupancy, times door/full.
// Latency: sensor edge to grant in 4 clk; occupancy visible 1 clk after grant. Backpressure: none, pending requests stay latched until served.
module parking_access_arbiter #(
   parameter int DOOR_CYCLES = 80000000,
   parameter int FULL_CYCLES = 40000000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       entry_sensor,
   input  logic       exit_sensor,
   input  logic [1:0] switch,
   output logic [3:0] parking_slots,
   output logic       door_open,
   output logic       full_flag,
   output logic [2:0] capacity,
   output logic [2:0] best_place,
   output logic       busy
);

   // One timer serves both hold periods, so it is sized to the longer one.
   // The largest value it ever holds is MAX_CYCLES-1, so it cannot wrap.
   localparam int MAX_CYCLES = (DOOR_CYCLES > FULL_CYCLES) ? DOOR_CYCLES : FULL_CYCLES;
   localparam int TW         = (MAX_CYCLES > 2) ? $clog2(MAX_CYCLES) : 1;
   localparam logic [TW-1:0] DOOR_LAST = TW'(DOOR_CYCLES - 1);
   localparam logic [TW-1:0] FULL_LAST = TW'(FULL_CYCLES - 1);

   typedef enum logic [1:0] {
      IDLE,
      ENTRY_OPEN,
      EXIT_OPEN,
      FULL_HOLD
   } state_t;

   typedef enum logic {
      SERVED_ENTRY,
      SERVED_EXIT
   } side_t;

   // Sensor synchronizers and edge-detect history
   logic entry_meta, entry_sync, entry_prev;
   logic exit_meta,  exit_sync,  exit_prev;
   logic entry_edge, exit_edge;

   // Arbiter state
   state_t        state_q,     state_d;
   logic [TW-1:0] timer_q,     timer_d;
   logic [3:0]    slots_q,     slots_d;
   logic          entry_req_q, entry_req_d;
   logic          exit_req_q,  exit_req_d;
   side_t         last_q,      last_d;
   logic          entry_grant, exit_grant;

   // Occupancy decode
   logic [1:0] lowest_idx;
   logic       lot_full;
   logic [2:0] free_cnt;
   logic [3:0] alloc_mask;
   logic [3:0] exit_mask;

   // Two-flop synchronizers plus one history flop per sensor for edge detection
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         entry_meta <= 1'b0;
         entry_sync <= 1'b0;
         entry_prev <= 1'b0;
         exit_meta  <= 1'b0;
         exit_sync  <= 1'b0;
         exit_prev  <= 1'b0;
      end else begin
         entry_meta <= entry_sensor;
         entry_sync <= entry_meta;
         entry_prev <= entry_sync;
         exit_meta  <= exit_sensor;
         exit_sync  <= exit_meta;
         exit_prev  <= exit_sync;
      end
   end

   assign entry_edge = entry_sync & ~entry_prev;
   assign exit_edge  = exit_sync  & ~exit_prev;

   // Free-slot count and lowest free index derived from occupancy
   always_comb begin
      free_cnt   = 3'd0;
      lowest_idx = 2'd0;
      lot_full   = 1'b1;
      for (int i = 0; i < 4; i++) begin
         if (!slots_q[i]) begin
            free_cnt = free_cnt + 3'd1;
         end
      end
      // Scan downward so the last hit is the lowest free slot
      for (int i = 3; i >= 0; i--) begin
         if (!slots_q[i]) begin
            lowest_idx = 2'(i);
            lot_full   = 1'b0;
         end
      end
   end

   assign alloc_mask = 4'b0001 << lowest_idx;
   assign exit_mask  = 4'b0001 << switch;

   // State, timer, occupancy, pending requests and round-robin pointer
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= IDLE;
         timer_q     <= '0;
         slots_q     <= 4'b0000;
         entry_req_q <= 1'b0;
         exit_req_q  <= 1'b0;
         last_q      <= SERVED_EXIT;
      end else begin
         state_q     <= state_d;
         timer_q     <= timer_d;
         slots_q     <= slots_d;
         entry_req_q <= entry_req_d;
         exit_req_q  <= exit_req_d;
         last_q      <= last_d;
      end
   end

   // Next-state logic: arbitration in IDLE, hold timing in the open/full states
   always_comb begin
      state_d     = state_q;
      timer_d     = timer_q;
      slots_d     = slots_q;
      last_d      = last_q;
      entry_grant = 1'b0;
      exit_grant  = 1'b0;

      case (state_q)
         IDLE: begin
            timer_d = '0;
            // Entry wins when it is alone, or when both wait and exit went last.
            // A rejection on a full lot still counts as serving entry.
            if (entry_req_q && (!exit_req_q || (last_q == SERVED_EXIT))) begin
               entry_grant = 1'b1;
               last_d      = SERVED_ENTRY;
               if (lot_full) begin
                  state_d = FULL_HOLD;
               end else begin
                  slots_d = slots_q | alloc_mask;
                  state_d = ENTRY_OPEN;
               end
            end else if (exit_req_q) begin
               // Clearing an already-free slot is harmless; the door opens anyway
               exit_grant = 1'b1;
               last_d     = SERVED_EXIT;
               slots_d    = slots_q & ~exit_mask;
               state_d    = EXIT_OPEN;
            end
         end

         ENTRY_OPEN, EXIT_OPEN: begin
            if (timer_q == DOOR_LAST) begin
               timer_d = '0;
               state_d = IDLE;
            end else begin
               timer_d = timer_q + TW'(1);
            end
         end

         FULL_HOLD: begin
            if (timer_q == FULL_LAST) begin
               timer_d = '0;
               state_d = IDLE;
            end else begin
               timer_d = timer_q + TW'(1);
            end
         end

         default: begin
            timer_d = '0;
            state_d = IDLE;
         end
      endcase
   end

   // Sticky requests: a repeat edge while pending is absorbed, a grant clears
   always_comb begin
      entry_req_d = (entry_req_q | entry_edge) & ~entry_grant;
      exit_req_d  = (exit_req_q  | exit_edge)  & ~exit_grant;
   end

   assign parking_slots = slots_q;
   assign capacity      = free_cnt;
   assign best_place    = lot_full ? 3'd0 : ({1'b0, lowest_idx} + 3'd1);
   assign door_open     = (state_q == ENTRY_OPEN) || (state_q == EXIT_OPEN);
   assign full_flag     = (state_q == FULL_HOLD);
   assign busy          = (state_q != IDLE);

endmodule

// File: tb/tb_parking_access_arbiter.sv
// Purpose: self-checking bench for parking_access_arbiter with a transaction-level model.
// Latency: windows measured per grant on falling edges.
// Backpressure: none; every wait is bounded.
module tb_parking_access_arbiter;

   localparam int DOOR = 8;
   localparam int FULL = 5;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       entry_sensor = 1'b0;
   logic       exit_sensor = 1'b0;
   logic [1:0] switch = 2'd0;
   logic [3:0] parking_slots;
   logic       door_open;
   logic       full_flag;
   logic [2:0] capacity;
   logic [2:0] best_place;
   logic       busy;

   int total = 0;
   int bad   = 0;

   // Reference model: occupancy and which side was served last
   logic [3:0] m_slots = 4'b0000;
   bit         m_last_exit = 1'b1;

   parking_access_arbiter #(
      .DOOR_CYCLES(DOOR),
      .FULL_CYCLES(FULL)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .entry_sensor (entry_sensor),
      .exit_sensor  (exit_sensor),
      .switch       (switch),
      .parking_slots(parking_slots),
      .door_open    (door_open),
      .full_flag    (full_flag),
      .capacity     (capacity),
      .best_place   (best_place),
      .busy         (busy)
   );

   always #5 clk = ~clk;

   function automatic int ref_capacity(input logic [3:0] s);
      int n = 0;
      for (int i = 0; i < 4; i++) if (s[i] == 1'b0) n++;
      return n;
   endfunction

   function automatic int ref_best(input logic [3:0] s);
      for (int i = 0; i < 4; i++) if (s[i] == 1'b0) return i + 1;
      return 0;
   endfunction

   task automatic do_reset();
      reset        = 1'b1;
      entry_sensor = 1'b0;
      exit_sensor  = 1'b0;
      repeat (2) @(negedge clk);
      reset       = 1'b0;
      m_slots     = 4'b0000;
      m_last_exit = 1'b1;
   endtask

   // One clean rising edge on the selected sensors, held 3 cycles
   task automatic pulse(input bit e, input bit x);
      @(negedge clk);
      entry_sensor = e;
      exit_sensor  = x;
      repeat (3) @(negedge clk);
      entry_sensor = 1'b0;
      exit_sensor  = 1'b0;
   endtask

   // Predict one grant, then observe its busy window and the occupancy it leaves.
   // inject: pulse entry twice during the window. no_gap: the window must start
   // on the cycle right after the previous window's single IDLE sample.
   task automatic serve_and_check(input bit is_entry, input bit inject, input bit no_gap, input string tag);
      int idle_wait, n_busy, n_door, n_full;
      bit full_case;
      full_case = is_entry && (m_slots == 4'b1111);
      if (is_entry) begin
         if (!full_case) m_slots[ref_best(m_slots) - 1] = 1'b1;
         m_last_exit = 1'b0;
      end else begin
         m_slots[switch] = 1'b0;
         m_last_exit = 1'b1;
      end

      idle_wait = 0;
      @(negedge clk);
      while (!busy && idle_wait < 40) begin
         idle_wait++;
         @(negedge clk);
      end
      total++;
      if (!busy) begin
         bad++;
         $display("FAIL %s_start: busy never rose within 40 cycles", tag);
         return;
      end
      if (no_gap) begin
         total++;
         if (idle_wait !== 0) begin
            bad++;
            $display("FAIL %s_gap: idle cycles got %0d want 1", tag, idle_wait + 1);
         end
      end
      total++;
      if (parking_slots !== m_slots) begin
         bad++;
         $display("FAIL %s_slots_first: got %b want %b", tag, parking_slots, m_slots);
      end

      n_busy = 0; n_door = 0; n_full = 0;
      while (busy && n_busy < 100) begin
         if (door_open) n_door++;
         if (full_flag) n_full++;
         // Switch moves after the exit grant; it must not disturb occupancy
         if (!is_entry && n_busy == 0) switch = switch + 2'd1;
         if (inject) entry_sensor = (n_busy == 0 || n_busy == 1 || n_busy == 4 || n_busy == 5);
         n_busy++;
         @(negedge clk);
      end
      if (inject) entry_sensor = 1'b0;

      total++;
      if (n_busy !== (full_case ? FULL : DOOR)) begin
         bad++;
         $display("FAIL %s_busy_len: got %0d want %0d", tag, n_busy, full_case ? FULL : DOOR);
      end
      total++;
      if (n_door !== (full_case ? 0 : DOOR)) begin
         bad++;
         $display("FAIL %s_door_len: got %0d want %0d", tag, n_door, full_case ? 0 : DOOR);
      end
      total++;
      if (n_full !== (full_case ? FULL : 0)) begin
         bad++;
         $display("FAIL %s_full_len: got %0d want %0d", tag, n_full, full_case ? FULL : 0);
      end
      total++;
      if (door_open !== 1'b0 || full_flag !== 1'b0) begin
         bad++;
         $display("FAIL %s_idle_outs: door=%b full=%b want 0 0", tag, door_open, full_flag);
      end
      total++;
      if (parking_slots !== m_slots) begin
         bad++;
         $display("FAIL %s_slots_end: got %b want %b", tag, parking_slots, m_slots);
      end
      total++;
      if (capacity !== 3'(ref_capacity(m_slots)) || best_place !== 3'(ref_best(m_slots))) begin
         bad++;
         $display("FAIL %s_cap_best: got cap=%0d best=%0d want cap=%0d best=%0d",
                  tag, capacity, best_place, ref_capacity(m_slots), ref_best(m_slots));
      end
   endtask

   // Both requests raised together: order follows the model's round-robin
   task automatic serve_both(input string tag);
      bit first_entry;
      first_entry = m_last_exit;
      serve_and_check(first_entry, 1'b0, 1'b0, {tag, "_first"});
      serve_and_check(!first_entry, 1'b0, 1'b1, {tag, "_second"});
   endtask

   task automatic check_slots_const(input logic [3:0] want, input string tag);
      total++;
      if (parking_slots !== want) begin
         bad++;
         $display("FAIL %s: slots got %b want %b", tag, parking_slots, want);
      end
   endtask

   task automatic check_quiet(input int cycles, input string tag);
      bit seen = 1'b0;
      repeat (cycles) begin
         @(negedge clk);
         if (busy) seen = 1'b1;
      end
      total++;
      if (seen) begin
         bad++;
         $display("FAIL %s: busy got 1 want 0 throughout %0d cycles", tag, cycles);
      end
   endtask

   task automatic test_reset();
      do_reset();
      @(negedge clk);
      total++;
      if (parking_slots !== 4'b0000 || door_open !== 1'b0 || full_flag !== 1'b0 ||
          busy !== 1'b0 || capacity !== 3'd4 || best_place !== 3'd1) begin
         bad++;
         $display("FAIL reset_state: slots=%b door=%b full=%b busy=%b cap=%0d best=%0d want 0000 0 0 0 4 1",
                  parking_slots, door_open, full_flag, busy, capacity, best_place);
      end
   endtask

   task automatic test_single_entry();
      pulse(1'b1, 1'b0);
      serve_and_check(1'b1, 1'b0, 1'b0, "entry1");
      check_slots_const(4'b0001, "entry1_const");
   endtask

   task automatic test_fill_and_full();
      for (int i = 0; i < 3; i++) begin
         pulse(1'b1, 1'b0);
         serve_and_check(1'b1, 1'b0, 1'b0, "fill");
      end
      check_slots_const(4'b1111, "fill_const");
      pulse(1'b1, 1'b0);
      serve_and_check(1'b1, 1'b0, 1'b0, "reject");
      check_slots_const(4'b1111, "reject_const");
   endtask

   task automatic test_exit_refill();
      switch = 2'd2;
      pulse(1'b0, 1'b1);
      serve_and_check(1'b0, 1'b0, 1'b0, "exit2");
      check_slots_const(4'b1011, "exit2_const");
      pulse(1'b1, 1'b0);
      serve_and_check(1'b1, 1'b0, 1'b0, "refill");
      check_slots_const(4'b1111, "refill_const");
   endtask

   task automatic test_simultaneous();
      do_reset();
      for (int i = 0; i < 3; i++) begin
         pulse(1'b1, 1'b0);
         serve_and_check(1'b1, 1'b0, 1'b0, "setup_entry");
      end
      switch = 2'd2;
      pulse(1'b0, 1'b1);
      serve_and_check(1'b0, 1'b0, 1'b0, "setup_exit");
      check_slots_const(4'b0011, "setup_const");
      switch = 2'd0;
      pulse(1'b1, 1'b1);
      serve_and_check(1'b1, 1'b0, 1'b0, "both_entry");
      serve_and_check(1'b0, 1'b0, 1'b1, "both_exit");
      check_slots_const(4'b0110, "both_const");
   endtask

   task automatic test_entry_during_exit();
      switch = 2'd1;
      pulse(1'b0, 1'b1);
      serve_and_check(1'b0, 1'b1, 1'b0, "exit_inject");
      serve_and_check(1'b1, 1'b0, 1'b1, "late_entry");
      check_slots_const(4'b0101, "late_entry_const");
      check_quiet(30, "single_alloc");
   endtask

   task automatic test_reset_mid();
      int n;
      do_reset();
      pulse(1'b1, 1'b0);
      n = 0;
      @(negedge clk);
      while (!busy && n < 40) begin
         n++;
         @(negedge clk);
      end
      repeat (3) @(negedge clk);
      total++;
      if (door_open !== 1'b1) begin
         bad++;
         $display("FAIL mid_door_before: got %b want 1", door_open);
      end
      #2 reset = 1'b1;
      #1;
      total++;
      if (door_open !== 1'b0 || busy !== 1'b0 || parking_slots !== 4'b0000 ||
          capacity !== 3'd4 || best_place !== 3'd1) begin
         bad++;
         $display("FAIL mid_reset: door=%b busy=%b slots=%b cap=%0d best=%0d want 0 0 0000 4 1",
                  door_open, busy, parking_slots, capacity, best_place);
      end
      @(negedge clk);
      reset       = 1'b0;
      m_slots     = 4'b0000;
      m_last_exit = 1'b1;
      check_quiet(30, "no_stale_grant");
      pulse(1'b1, 1'b0);
      serve_and_check(1'b1, 1'b0, 1'b0, "post_reset_entry");
   endtask

   task automatic test_random();
      int r;
      do_reset();
      for (int k = 0; k < 25; k++) begin
         r = $urandom_range(0, 3);
         switch = 2'($urandom_range(0, 3));
         if (r <= 1) begin
            pulse(1'b1, 1'b0);
            serve_and_check(1'b1, 1'b0, 1'b0, "rnd_entry");
         end else if (r == 2) begin
            pulse(1'b0, 1'b1);
            serve_and_check(1'b0, 1'b0, 1'b0, "rnd_exit");
         end else begin
            pulse(1'b1, 1'b1);
            serve_both("rnd_both");
         end
         repeat ($urandom_range(0, 3)) @(negedge clk);
      end
   endtask

   initial begin
      test_reset();
      test_single_entry();
      test_fill_and_full();
      test_exit_refill();
      test_simultaneous();
      test_entry_during_exit();
      test_reset_mid();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/parking_access_arbiter.md
Name: parking_access_arbiter

Overview:
- Sequencing controller for the 4-slot parking datapath; owns the slot occupancy register.
- Arbitrates entry and exit requests from the two gate sensors and allocates the lowest-numbered free slot on entry.
- Frees the operator-selected slot on exit; drives the door-open and lot-full handshakes.
- Supplies slot, capacity and best-place values to the LED and seven-segment logic; runs on the 40 MHz system clock.

Parameters:
DOOR_CYCLES, 80000000, clk cycles the door stays open per granted request (2 s at 40 MHz); must be >=2.
FULL_CYCLES, 40000000, clk cycles full_flag is held after a rejected entry; must be >=2.

Ports:
clk  input  1  system clock, 40 MHz
reset  input  1  asynchronous, active-high; clears all state
entry_sensor  input  1  raw level from entry sensor, asynchronous to clk
exit_sensor  input  1  raw level from exit sensor, asynchronous to clk
switch  input  2  index (0..3) of the slot being vacated, sampled on exit grant
parking_slots  output  4  occupancy, bit i = slot i occupied
door_open  output  1  high while the door is open
full_flag  output  1  high while a rejected-entry indication is active
capacity  output  3  free slot count, 0..4
best_place  output  3  next slot to allocate, 1..4; 0 when lot is full
busy  output  1  high in any state other than IDLE

Behaviour:
- Both sensors pass through a 2-flop synchronizer, then a rising-edge detector; edges become request bits.
- Request bits are sticky: set on edge, cleared only when the request is granted or rejected.
- Reset: all registers cleared. parking_slots=0, door_open=0, full_flag=0, busy=0, capacity=4, best_place=1, both requests cleared, last_served=EXIT.
- capacity and best_place are combinational from parking_slots.
  - capacity = number of zero bits.
  - best_place = 1 + index of the lowest zero bit, or 0 if all bits are set.
- FSM states: IDLE, ENTRY_OPEN, EXIT_OPEN, FULL_HOLD.
- IDLE, evaluated each cycle:
  - Only the entry request pending:
    - lot not full: set slot (best_place-1), clear the request, go to ENTRY_OPEN.
    - lot full: clear the request, go to FULL_HOLD.
  - Only the exit request pending: go to EXIT_OPEN.
    - If slot[switch] is set, clear it.
    - If slot[switch] is already clear, occupancy is unchanged but the door still opens.
    - In both cases clear the request.
  - Both requests pending: serve the side opposite to last_served (round-robin). The other request stays pending.
  - Update last_served on every grant. A FULL_HOLD rejection counts as serving ENTRY.
- Occupancy update and the state change occur on the same clock edge. parking_slots shows the new value one cycle after the IDLE decision edge.
- ENTRY_OPEN / EXIT_OPEN:
  - door_open=1 for exactly DOOR_CYCLES cycles, counted from the first cycle in the state.
  - Then return to IDLE with door_open=0.
- FULL_HOLD:
  - full_flag=1 for exactly FULL_CYCLES cycles; door_open stays 0.
  - Then return to IDLE.
- Requests arriving in a non-IDLE state are latched and served after return to IDLE. The earliest service is the first IDLE cycle.
- A second edge on an already-pending request is absorbed; there is no counting.
- switch is sampled only on the exit grant edge; later changes have no effect.
- Wrap and boundary handling:
  - Timers are sized to the larger parameter and never wrap.
  - Allocation never sets an occupied bit.
  - Exit never clears an unselected bit.
- Reset asserted mid-operation: immediate return to IDLE. Outputs, timers and pending requests clear; occupancy returns to all-empty.

Test Plan:
(Run with DOOR_CYCLES=8, FULL_CYCLES=5.)
1. Reset, then one entry edge -> parking_slots=0001, capacity=3, best_place=2, door_open high for exactly 8 cycles, busy high during the same window.
2. Four entries, then a fifth -> slots 1111, capacity=0, best_place=0; fifth gives full_flag high 5 cycles, door_open stays 0, slots unchanged.
3. Slots 1111, switch=2, exit edge -> parking_slots=1011, best_place=3, capacity=1, door_open 8 cycles. Next entry refills slot 2, giving 1111.
4. Entry and exit edges in the same cycle from reset-fresh state with slots 0011, switch=0 -> ENTRY served first, then EXIT.
   - After both complete: slots 0110.
   - door_open shows two 8-cycle windows separated by one IDLE cycle.
5. Entry edge during EXIT_OPEN, plus a repeated entry edge -> exactly one allocation after the door closes.
6. Assert reset at cycle 4 of ENTRY_OPEN -> door_open and busy drop asynchronously, parking_slots=0000, capacity=4, best_place=1. No stale grant after reset release.
